// File: rtl/nonce_collector_pkg.sv
// Shared constants for the nonce collector: FSM encoding, default warm-up depth
// and nonce width.
package nonce_collector_pkg;
  localparam int NONCE_W    = 32;
  localparam int WARMUP_DEF = 174;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RST  = 2'd1;
  localparam logic [1:0] ST_WARM = 2'd2;
  localparam logic [1:0] ST_SCAN = 2'd3;
endpackage

// File: rtl/nonce_collector_result_fifo.sv
// Synchronous result FIFO with flush and a registered head word (zero when empty).
module result_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             flush,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] head
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr, rd_ptr, wr_nxt, rd_nxt;
  logic             wr_en, rd_en;

  assign empty  = (wr_ptr == rd_ptr);
  assign full   = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign rd_en  = pop && !empty;
  // When full, a push is only taken if the head leaves in the same cycle.
  assign wr_en  = push && (!full || rd_en);
  assign wr_nxt = wr_ptr + {{AW{1'b0}}, wr_en};
  assign rd_nxt = rd_ptr + {{AW{1'b0}}, rd_en};

  always_ff @(posedge clk) begin
    if (reset_n && !flush && wr_en)
      mem[wr_ptr[AW-1:0]] <= din;
  end

  // Head tracks the entry at rd_nxt; bypass din when that slot is written now.
  always_ff @(posedge clk) begin
    if (!reset_n || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      head   <= '0;
    end else begin
      wr_ptr <= wr_nxt;
      rd_ptr <= rd_nxt;
      if (wr_nxt == rd_nxt)
        head <= '0;
      else if (wr_en && (wr_ptr == rd_nxt))
        head <= din;
      else
        head <= mem[rd_nxt[AW-1:0]];
    end
  end
endmodule

// File: rtl/nonce_collector.sv
// Per-job controller for the Groestl miner: restarts it, masks warm-up, scans a
// bounded window and queues found nonces for the host.
module nonce_collector
  import nonce_collector_pkg::*;
#(
  parameter int DEPTH      = 8,
  parameter int WARMUP     = WARMUP_DEF,
  parameter int RST_CYCLES = 2
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               job_start,
  input  logic [NONCE_W-1:0] job_nonce_start,
  input  logic [31:0]        job_count,
  output logic               miner_reset,
  output logic [NONCE_W-1:0] miner_nonce_start,
  input  logic               miner_found,
  input  logic [NONCE_W-1:0] miner_nonce,
  output logic               res_valid,
  input  logic               res_ready,
  output logic [NONCE_W-1:0] res_nonce,
  output logic               job_busy,
  output logic               job_done,
  output logic               overflow,
  output logic               sync_err,
  output logic [15:0]        found_count
);
  localparam int CMAX = (WARMUP > RST_CYCLES) ? WARMUP : RST_CYCLES;
  localparam int CW   = $clog2(CMAX) + 1;

  logic [1:0]    state;
  logic [CW-1:0] cnt;
  logic [31:0]   remaining, count_q;
  logic          first_q;
  logic          fifo_full, fifo_empty, push, pop;

  assign miner_reset = (state == ST_IDLE) || (state == ST_RST);
  assign job_busy    = (state != ST_IDLE);
  assign res_valid   = !fifo_empty;
  assign pop         = res_valid && res_ready;
  assign push        = (state == ST_SCAN) && miner_found && !job_start;

  result_fifo #(.DEPTH(DEPTH), .WIDTH(NONCE_W)) u_fifo (
    .clk    (clk),
    .reset_n(reset_n),
    .flush  (job_start),
    .push   (push),
    .pop    (pop),
    .din    (miner_nonce),
    .full   (fifo_full),
    .empty  (fifo_empty),
    .head   (res_nonce)
  );

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state             <= ST_IDLE;
      cnt               <= '0;
      remaining         <= '0;
      count_q           <= '0;
      first_q           <= 1'b0;
      miner_nonce_start <= '0;
      job_done          <= 1'b0;
      overflow          <= 1'b0;
      sync_err          <= 1'b0;
      found_count       <= '0;
    end else begin
      job_done <= 1'b0;
      // A new job pre-empts whatever is running, including an active scan.
      if (job_start) begin
        state             <= ST_RST;
        cnt               <= CW'(RST_CYCLES - 1);
        miner_nonce_start <= job_nonce_start;
        count_q           <= job_count;
        overflow          <= 1'b0;
        sync_err          <= 1'b0;
        found_count       <= '0;
      end else begin
        case (state)
          ST_RST: begin
            if (cnt == '0) begin
              state <= ST_WARM;
              cnt   <= CW'(WARMUP - 1);
            end else begin
              cnt <= cnt - 1'b1;
            end
          end
          ST_WARM: begin
            if (cnt != '0) begin
              cnt <= cnt - 1'b1;
            end else if (count_q == '0) begin
              state    <= ST_IDLE;
              job_done <= 1'b1;
            end else begin
              state     <= ST_SCAN;
              remaining <= count_q;
              first_q   <= 1'b1;
            end
          end
          ST_SCAN: begin
            first_q   <= 1'b0;
            remaining <= remaining - 1'b1;
            if (first_q && (miner_nonce != miner_nonce_start))
              sync_err <= 1'b1;
            if (miner_found) begin
              if (found_count != 16'hFFFF)
                found_count <= found_count + 16'd1;
              if (fifo_full && !pop)
                overflow <= 1'b1;
            end
            if (remaining == 32'd1) begin
              state    <= ST_IDLE;
              job_done <= 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end
endmodule
